// File: rtl/ase_sim_local_mem_pkg.sv
// Shared constants and width helpers for the local-memory AVMM latency bridge.
package ase_sim_local_mem_pkg;

  // The command skid buffer is two deep so waitrequest can come straight from a flop.
  localparam int unsigned CmdFifoDepth = 2;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ase_sim_local_mem_fifo.sv
// Generic synchronous FIFO with registered storage and fall-through head; DEPTH is a power of 2.
module ase_sim_local_mem_fifo
  import ase_sim_local_mem_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [WIDTH-1:0]              din_i,
  output logic [WIDTH-1:0]              dout_o,
  output logic                          empty_o,
  output logic                          full_o,
  output logic [cnt_width(DEPTH)-1:0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
      else if (!push_ok && pop_ok) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/ase_sim_local_mem_avmm_latency_bridge.sv
// AVMM bridge between the AFU slave and EMIF master: skid-buffered commands, credit-managed
// read-response FIFO with a programmable extra read latency.
module ase_sim_local_mem_avmm_latency_bridge
  import ase_sim_local_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = 512,
  parameter int unsigned ADDR_WIDTH         = 27,
  parameter int unsigned BURST_CNT_WIDTH    = 7,
  parameter int unsigned RSP_FIFO_DEPTH     = 128,
  parameter int unsigned EXTRA_READ_LATENCY = 0,
  parameter int unsigned TS_WIDTH           = 16
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  output logic                                 s0_waitrequest_o,
  input  logic [ADDR_WIDTH-1:0]                s0_address_i,
  input  logic [BURST_CNT_WIDTH-1:0]           s0_burstcount_i,
  input  logic                                 s0_read_i,
  input  logic                                 s0_write_i,
  input  logic [DATA_WIDTH-1:0]                s0_writedata_i,
  input  logic [DATA_WIDTH/8-1:0]              s0_byteenable_i,
  output logic [DATA_WIDTH-1:0]                s0_readdata_o,
  output logic                                 s0_readdatavalid_o,
  input  logic                                 m0_waitrequest_i,
  output logic [ADDR_WIDTH-1:0]                m0_address_o,
  output logic [BURST_CNT_WIDTH-1:0]           m0_burstcount_o,
  output logic                                 m0_read_o,
  output logic                                 m0_write_o,
  output logic [DATA_WIDTH-1:0]                m0_writedata_o,
  output logic [DATA_WIDTH/8-1:0]              m0_byteenable_o,
  input  logic [DATA_WIDTH-1:0]                m0_readdata_i,
  input  logic                                 m0_readdatavalid_i,
  output logic [cnt_width(RSP_FIFO_DEPTH)-1:0] rd_outstanding_o,
  output logic                                 err_rsp_overflow_o
);

  // Packages cannot take parameters, so the command record lives here.
  typedef struct packed {
    logic                       read;
    logic                       write;
    logic [ADDR_WIDTH-1:0]      addr;
    logic [BURST_CNT_WIDTH-1:0] burstcount;
    logic [DATA_WIDTH-1:0]      data;
    logic [DATA_WIDTH/8-1:0]    be;
  } t_avmm_cmd;

  localparam int unsigned CmdW    = $bits(t_avmm_cmd);
  localparam int unsigned CmdCntW = cnt_width(CmdFifoDepth);
  localparam int unsigned OutW    = cnt_width(RSP_FIFO_DEPTH);
  localparam int unsigned SumW    = ((OutW > BURST_CNT_WIDTH) ? OutW : BURST_CNT_WIDTH) + 1;
  localparam int unsigned RspW    = DATA_WIDTH + TS_WIDTH;

  t_avmm_cmd            cmd_in, cmd_head;
  logic                 cmd_push, cmd_pop, cmd_empty, cmd_full;
  logic [CmdCntW-1:0]   cmd_cnt, cmd_cnt_d;
  logic                 wait_q, wait_d;
  logic                 credit_ok, rd_pop;
  logic [OutW-1:0]      rd_out_q, rd_out_d;

  logic [TS_WIDTH-1:0]  ts_q, rsp_age;
  logic [RspW-1:0]      rsp_din, rsp_dout;
  logic                 rsp_push, rsp_pop, rsp_empty, rsp_full, rsp_drop;
  logic [OutW-1:0]      rsp_cnt;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                 err_q;
  logic                 unused_cnt;

  // ---------------- command path ----------------
  assign cmd_in   = '{read: s0_read_i, write: s0_write_i, addr: s0_address_i,
                      burstcount: s0_burstcount_i, data: s0_writedata_i, be: s0_byteenable_i};
  assign cmd_push = (s0_read_i | s0_write_i) & ~wait_q;

  ase_sim_local_mem_fifo #(
    .WIDTH (CmdW),
    .DEPTH (CmdFifoDepth)
  ) u_cmd_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (cmd_push),
    .pop_i     (cmd_pop),
    .din_i     (cmd_in),
    .dout_o    (cmd_head),
    .empty_o   (cmd_empty),
    .full_o    (cmd_full),
    .count_o   (cmd_cnt)
  );

  // Reads only issue once their whole burst is guaranteed room in the response FIFO.
  assign credit_ok = (SumW'(rd_out_q) + SumW'(cmd_head.burstcount)) <= SumW'(RSP_FIFO_DEPTH);
  assign m0_read_o  = ~cmd_empty & cmd_head.read & credit_ok;
  assign m0_write_o = ~cmd_empty & cmd_head.write & ~cmd_head.read;
  assign m0_address_o    = cmd_head.addr;
  assign m0_burstcount_o = cmd_head.burstcount;
  assign m0_writedata_o  = cmd_head.data;
  assign m0_byteenable_o = cmd_head.be;
  assign cmd_pop = (m0_read_o | m0_write_o) & ~m0_waitrequest_i;
  assign rd_pop  = m0_read_o & ~m0_waitrequest_i;
  assign s0_waitrequest_o = wait_q;

  always_comb begin
    cmd_cnt_d = cmd_cnt;
    if (cmd_push) cmd_cnt_d = cmd_cnt_d + 1'b1;
    if (cmd_pop)  cmd_cnt_d = cmd_cnt_d - 1'b1;
    wait_d = (cmd_cnt_d == CmdCntW'(CmdFifoDepth));
  end

  always_comb begin
    rd_out_d = rd_out_q;
    if (rd_pop)  rd_out_d = rd_out_d + OutW'(cmd_head.burstcount);
    if (rsp_pop) rd_out_d = rd_out_d - 1'b1;
  end

  // ---------------- response path ----------------
  assign rsp_drop = m0_readdatavalid_i & (rsp_full | (rd_out_q == '0));
  assign rsp_push = m0_readdatavalid_i & ~rsp_drop;
  assign rsp_din  = {m0_readdata_i, ts_q};

  ase_sim_local_mem_fifo #(
    .WIDTH (RspW),
    .DEPTH (RSP_FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (rsp_push),
    .pop_i     (rsp_pop),
    .din_i     (rsp_din),
    .dout_o    (rsp_dout),
    .empty_o   (rsp_empty),
    .full_o    (rsp_full),
    .count_o   (rsp_cnt)
  );

  // Modulo age is safe: every beat leaves exactly EXTRA_READ_LATENCY+1 cycles after arrival.
  assign rsp_age = ts_q - rsp_dout[TS_WIDTH-1:0];
  assign rsp_pop = ~rsp_empty & (rsp_age >= TS_WIDTH'(EXTRA_READ_LATENCY + 1));

  assign s0_readdatavalid_o = rsp_pop;
  assign s0_readdata_o      = rsp_pop ? rsp_dout[TS_WIDTH +: DATA_WIDTH] : rdata_q;
  assign rd_outstanding_o   = rd_out_q;
  assign err_rsp_overflow_o = err_q;
  assign unused_cnt         = cmd_full ^ (^rsp_cnt);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wait_q   <= 1'b1;
      rd_out_q <= '0;
      ts_q     <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wait_q   <= wait_d;
      rd_out_q <= rd_out_d;
      ts_q     <= ts_q + 1'b1;
      if (rsp_pop) rdata_q <= rsp_dout[TS_WIDTH +: DATA_WIDTH];
      err_q    <= err_q | rsp_drop;
    end
  end

endmodule

// File: tb/tb_ase_sim_local_mem_avmm_latency_bridge.sv
// Scoreboard bench: stimulus queues expected m0 commands and s0 read beats, a monitor checks them.
module tb_ase_sim_local_mem_avmm_latency_bridge;

  localparam int DW = 32;
  localparam int AW = 27;
  localparam int BW = 4;
  localparam int DEPTH = 8;
  localparam int OW = 4;
  localparam int XL = 20;
  localparam int TSW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          s0_waitrequest;
  logic [AW-1:0] s0_address;
  logic [BW-1:0] s0_burstcount;
  logic          s0_read, s0_write;
  logic [DW-1:0] s0_writedata;
  logic [3:0]    s0_byteenable;
  logic [DW-1:0] s0_readdata;
  logic          s0_readdatavalid;
  logic          m0_waitrequest;
  logic [AW-1:0] m0_address;
  logic [BW-1:0] m0_burstcount;
  logic          m0_read, m0_write;
  logic [DW-1:0] m0_writedata;
  logic [3:0]    m0_byteenable;
  logic [DW-1:0] m0_readdata;
  logic          m0_readdatavalid;
  logic [OW-1:0] rd_outstanding;
  logic          err_rsp_overflow;

  always #5 clk = ~clk;

  ase_sim_local_mem_avmm_latency_bridge #(
    .DATA_WIDTH         (DW),
    .ADDR_WIDTH         (AW),
    .BURST_CNT_WIDTH    (BW),
    .RSP_FIFO_DEPTH     (DEPTH),
    .EXTRA_READ_LATENCY (XL),
    .TS_WIDTH           (TSW)
  ) dut (
    .clk_i              (clk),
    .reset_n_i          (reset_n),
    .s0_waitrequest_o   (s0_waitrequest),
    .s0_address_i       (s0_address),
    .s0_burstcount_i    (s0_burstcount),
    .s0_read_i          (s0_read),
    .s0_write_i         (s0_write),
    .s0_writedata_i     (s0_writedata),
    .s0_byteenable_i    (s0_byteenable),
    .s0_readdata_o      (s0_readdata),
    .s0_readdatavalid_o (s0_readdatavalid),
    .m0_waitrequest_i   (m0_waitrequest),
    .m0_address_o       (m0_address),
    .m0_burstcount_o    (m0_burstcount),
    .m0_read_o          (m0_read),
    .m0_write_o         (m0_write),
    .m0_writedata_o     (m0_writedata),
    .m0_byteenable_o    (m0_byteenable),
    .m0_readdata_i      (m0_readdata),
    .m0_readdatavalid_i (m0_readdatavalid),
    .rd_outstanding_o   (rd_outstanding),
    .err_rsp_overflow_o (err_rsp_overflow)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int last_rd_cyc = -1;
  logic [68:0] exp_m0_q[$];
  int          exp_m0_cyc_q[$];
  logic [DW-1:0] exp_s0_q[$];
  int          exp_s0_cyc_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares every completed m0 command and every s0 read beat with the scoreboard.
  initial begin
    forever begin
      logic [68:0] e;
      int ec;
      @(negedge clk);
      if (reset_n) begin
        if ((m0_read || m0_write) && !m0_waitrequest) begin
          if (exp_m0_q.size() == 0) chk("m0_unexpected", 1, 0);
          else begin
            e  = exp_m0_q.pop_front();
            ec = exp_m0_cyc_q.pop_front();
            chk("m0_cmd", {m0_read, m0_write, m0_address, m0_burstcount, m0_writedata,
                           m0_byteenable}, e);
            if (ec >= 0) chk("m0_cycle", cyc, ec);
          end
          if (m0_read) begin
            last_rd_cyc = cyc;
            chk("m0_credit", (rd_outstanding + m0_burstcount) <= DEPTH, 1);
          end
        end
        if (s0_readdatavalid) begin
          if (exp_s0_q.size() == 0) chk("s0_unexpected", 1, 0);
          else begin
            chk("s0_data", s0_readdata, exp_s0_q.pop_front());
            chk("s0_cycle", cyc, exp_s0_cyc_q.pop_front());
          end
        end
      end
    end
  end

  task automatic present(input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [BW-1:0] bc, input logic [DW-1:0] d, input logic [3:0] be);
    s0_read = rd; s0_write = wr; s0_address = a;
    s0_burstcount = bc; s0_writedata = d; s0_byteenable = be;
  endtask

  task automatic idle();
    s0_read = 1'b0; s0_write = 1'b0;
  endtask

  // One cycle of an offered command; lat >= 0 fixes the m0 cycle relative to acceptance.
  task automatic step(input int lat, output bit acc);
    @(negedge clk);
    acc = !s0_waitrequest && (s0_read || s0_write);
    if (acc) begin
      exp_m0_q.push_back({s0_read, s0_write, s0_address, s0_burstcount, s0_writedata,
                          s0_byteenable});
      exp_m0_cyc_q.push_back((lat >= 0) ? cyc + lat : -1);
    end
    @(posedge clk); #1;
  endtask

  task automatic send(input logic rd, input logic wr, input logic [AW-1:0] a,
                      input logic [BW-1:0] bc, input logic [DW-1:0] d, input logic [3:0] be,
                      input int lat);
    bit acc = 1'b0;
    present(rd, wr, a, bc, d, be);
    for (int i = 0; i < 100 && !acc; i++) step(lat, acc);
    if (!acc) chk("s0_accept_timeout", 0, 1);
  endtask

  // EMIF model: eight consecutive beats; each must reach s0 XL+1 cycles later.
  task automatic emif_return(input logic [DW-1:0] base);
    for (int i = 0; i < 8; i++) begin
      m0_readdatavalid = 1'b1;
      m0_readdata = base + DW'(i);
      exp_s0_q.push_back(base + DW'(i));
      exp_s0_cyc_q.push_back(cyc + XL + 1);
      @(posedge clk); #1;
    end
    m0_readdatavalid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int n;
    bit acc;
    reset_n = 1'b0;
    idle();
    s0_address = '0; s0_burstcount = '0; s0_writedata = '0; s0_byteenable = '0;
    m0_waitrequest = 1'b0; m0_readdata = '0; m0_readdatavalid = 1'b0;

    // reset
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("rst_waitrequest", s0_waitrequest, 1);
    chk("rst_m0_read", m0_read, 0);
    chk("rst_m0_write", m0_write, 0);
    chk("rst_s0_rdv", s0_readdatavalid, 0);
    chk("rst_err", err_rsp_overflow, 0);
    chk("rst_rd_outstanding", rd_outstanding, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_waitrequest_before_edge", s0_waitrequest, 1);
    @(negedge clk);
    chk("rel_waitrequest_after_edge", s0_waitrequest, 0);
    chk("rel_m0_read", m0_read, 0);
    chk("rel_m0_write", m0_write, 0);
    chk("rel_rd_outstanding", rd_outstanding, 0);
    @(posedge clk); #1;

    // write burst pass-through, each beat on m0 one cycle after acceptance
    for (int i = 0; i < 4; i++) send(1'b0, 1'b1, 27'h100, 4'd4, 32'hA0 + i, 4'hF, 1);
    idle();
    repeat (3) @(posedge clk); #1;

    // back-pressure: only the two skid entries are taken while m0 stalls
    m0_waitrequest = 1'b1;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      present(1'b0, 1'b1, 27'h200 + k, 4'd1, 32'hB0 + k, 4'h3);
      step(-1, acc);
      if (acc) k++;
    end
    chk("bp_accepted", k, 2);
    chk("bp_waitrequest", s0_waitrequest, 1);
    m0_waitrequest = 1'b0;
    for (; k < 6; k++) send(1'b0, 1'b1, 27'h200 + k, 4'd1, 32'hB0 + k, 4'h3, -1);
    idle();
    repeat (5) @(posedge clk); #1;
    chk("bp_m0_drained", exp_m0_q.size(), 0);

    // credit stall: the second 8-beat read waits for all 8 credits to return
    send(1'b1, 1'b0, 27'h300, 4'd8, 32'h0, 4'hF, 1);
    send(1'b1, 1'b0, 27'h308, 4'd8, 32'h0, 4'hF, -1);
    idle();
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("stall_m0_read", m0_read, 0);
    chk("stall_rd_outstanding_peak", rd_outstanding, 8);
    @(posedge clk); #1;
    n = cyc;
    emif_return(32'hC0);
    for (int i = 0; i < 100 && last_rd_cyc < n; i++) @(posedge clk);
    chk("credit_reissue_cycle", last_rd_cyc, n + 8 + XL + 1);
    @(negedge clk);
    chk("s0_rdv_idle", s0_readdatavalid, 0);
    chk("s0_readdata_hold", s0_readdata, 32'hC7);
    chk("second_rd_outstanding", rd_outstanding, 8);
    @(posedge clk); #1;
    emif_return(32'hD0);
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("drained_rd_outstanding", rd_outstanding, 0);
    chk("drained_s0_queue", exp_s0_q.size(), 0);
    @(posedge clk); #1;

    // error path: unsolicited beat is dropped and the flag sticks
    chk("pre_err", err_rsp_overflow, 0);
    m0_readdatavalid = 1'b1;
    m0_readdata = 32'hEE;
    @(posedge clk); #1;
    m0_readdatavalid = 1'b0;
    @(negedge clk);
    chk("err_set", err_rsp_overflow, 1);
    repeat (25) @(posedge clk);
    @(negedge clk);
    chk("err_sticky", err_rsp_overflow, 1);
    chk("err_rd_outstanding", rd_outstanding, 0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    chk("err_cleared_by_reset", err_rsp_overflow, 0);
    chk("reset_waitrequest", s0_waitrequest, 1);
    chk("final_m0_queue", exp_m0_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
